// File: rtl/arcade_dl_pkg.sv
// Shared definitions for the arcade ROM download path.
// Contents:
//   dl_state_t - loader FSM states.
//   region_t   - region index; wide enough for 8 regions plus the REG_NONE marker.
//   REG_NONE   - region index reported when no region claims an address.
//   IOCTL_AW   - width of the hps_io byte address.
//   FILL_BYTE  - value used for the missing half of an incomplete 16-bit word.
package arcade_dl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    HOLD  = 3'd3,
    READY = 3'd4
  } dl_state_t;

  typedef logic [3:0] region_t;

  localparam region_t    REG_NONE  = 4'hF;
  localparam int         IOCTL_AW  = 25;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/dl_region_decode.sv
// Combinational address decoder: maps an ioctl byte address onto one of NREG
// regions, each described by a 25-bit byte base and size.
// Ports:
//   addr   in   25  ioctl byte address
//   hit    out  1   some region contains addr
//   region out  4   index of the lowest-numbered matching region (REG_NONE on miss)
//   offset out  25  byte offset of addr from that region's base (0 on miss)
module dl_region_decode
  import arcade_dl_pkg::*;
#(
  parameter int                   NREG     = 4,
  parameter logic [NREG*25-1:0]   REG_BASE = {NREG{25'h0}},
  parameter logic [NREG*25-1:0]   REG_SIZE = {NREG{25'h40000}}
) (
  input  logic [IOCTL_AW-1:0] addr,
  output logic                hit,
  output region_t             region,
  output logic [IOCTL_AW-1:0] offset
);

  logic [NREG-1:0]     match;
  logic [IOCTL_AW-1:0] offs [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [IOCTL_AW:0]   BASE = {1'b0, REG_BASE[gi*IOCTL_AW +: IOCTL_AW]};
      localparam logic [IOCTL_AW-1:0] SIZE = REG_SIZE[gi*IOCTL_AW +: IOCTL_AW];
      logic [IOCTL_AW:0] diff;

      // One extra bit makes the subtraction's sign bit a clean addr<base test,
      // so no separate lower-bound comparison is needed.
      assign diff       = {1'b0, addr} - BASE;
      assign match[gi]  = !diff[IOCTL_AW] && (diff[IOCTL_AW-1:0] < SIZE);
      assign offs[gi]   = diff[IOCTL_AW-1:0];
    end
  endgenerate

  // Walk from the top down so the lowest matching region is the last writer.
  always_comb begin
    hit    = |match;
    region = REG_NONE;
    offset = '0;
    for (int r = NREG - 1; r >= 0; r--) begin
      if (match[r]) begin
        region = region_t'(r);
        offset = offs[r];
      end
    end
  end

endmodule

// File: rtl/arcade_rom_loader.sv
// ROM download router between the hps_io ioctl byte stream and an arcade
// core's ROM/RAM write ports. Bytes of a matching download are steered to one
// of NREG regions, packed into DATA_W-bit words (16: little-endian pairs) and
// written through a one-hot strobe. The core is held in reset while loading
// and for HOLD_CYC cycles afterwards, then rom_ready rises.
// Ports:
//   clk_sys        in   1       system clock
//   reset          in   1       synchronous, active-high
//   ioctl_download in   1       download active
//   ioctl_wr       in   1       byte strobe (1-cycle pulse)
//   ioctl_addr     in   25      byte address
//   ioctl_dout     in   8       byte data
//   ioctl_index    in   16      download index
//   dn_addr        out  ADDR_W  word address relative to region base
//   dn_data        out  DATA_W  packed word
//   dn_wr          out  NREG    one-hot write strobe, 1 cycle
//   reset_out      out  1       core reset request
//   rom_ready      out  1       ROM image complete
//   oob_err        out  1       sticky: a byte fell outside every region
module arcade_rom_loader
  import arcade_dl_pkg::*;
#(
  parameter int                 NREG      = 4,
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 18,
  parameter logic [15:0]        ROM_INDEX = 16'd0,
  parameter logic [NREG*25-1:0] REG_BASE  = {NREG{25'h0}},
  parameter logic [NREG*25-1:0] REG_SIZE  = {NREG{25'h40000}},
  parameter int                 HOLD_CYC  = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic [15:0]         ioctl_index,
  output logic [ADDR_W-1:0]   dn_addr,
  output logic [DATA_W-1:0]   dn_data,
  output logic [NREG-1:0]     dn_wr,
  output logic                reset_out,
  output logic                rom_ready,
  output logic                oob_err
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  dl_state_t           state_reg, state_next;
  logic [CNT_W-1:0]    hold_cnt_reg;

  logic                dec_hit;
  region_t             dec_region;
  logic [IOCTL_AW-1:0] dec_offset;

  logic                start_dl;
  logic                enter_load;
  logic                byte_ok;
  logic                byte_oob;

  // Write request produced by the packing stage, registered onto dn_* below.
  logic                wr_en;
  region_t             wr_region;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  dl_region_decode #(
    .NREG     (NREG),
    .REG_BASE (REG_BASE),
    .REG_SIZE (REG_SIZE)
  ) u_decode (
    .addr   (ioctl_addr),
    .hit    (dec_hit),
    .region (dec_region),
    .offset (dec_offset)
  );

  assign start_dl   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign enter_load = ((state_reg == IDLE) || (state_reg == READY)) && start_dl;
  assign byte_ok    = (state_reg == LOAD) && ioctl_wr && dec_hit;
  assign byte_oob   = (state_reg == LOAD) && ioctl_wr && !dec_hit;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, READY: if (start_dl)        state_next = LOAD;
      LOAD:        if (!ioctl_download) state_next = FLUSH;
      FLUSH:                            state_next = HOLD;
      HOLD:        if (hold_cnt_reg == '0) state_next = READY;
      default:                          state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- packing
  generate
    if (DATA_W == 16) begin : g_w16
      // One-byte pending slot. An even byte waits there for its odd partner.
      // An odd byte only lands there when it arrives in the same cycle that an
      // older half-word has to be flushed; it is then written on the next
      // free cycle, which keeps the output at one write per cycle.
      logic              pend_valid_reg, pend_valid_next;
      logic              pend_odd_reg,   pend_odd_next;
      logic [7:0]        pend_byte_reg,  pend_byte_next;
      region_t           pend_region_reg, pend_region_next;
      logic [IOCTL_AW-1:0] pend_baddr_reg, pend_baddr_next;
      logic [ADDR_W-1:0] pend_waddr_reg, pend_waddr_next;
      logic [IOCTL_AW-1:0] word_off;
      logic              pair_hit;
      logic              take_new;
      logic              unused_w16;

      assign word_off   = {1'b0, dec_offset[IOCTL_AW-1:1]};
      assign unused_w16 = ^word_off;

      // Parity is taken from the region offset, not the absolute address,
      // so pairing stays correct even for an odd region base.
      assign pair_hit = pend_valid_reg && !pend_odd_reg && dec_offset[0] &&
                        (dec_region == pend_region_reg) &&
                        (ioctl_addr == pend_baddr_reg + 25'd1);

      always_comb begin
        wr_en            = 1'b0;
        wr_region        = pend_region_reg;
        wr_addr          = pend_waddr_reg;
        wr_data          = pend_odd_reg ? {pend_byte_reg, FILL_BYTE}
                                        : {FILL_BYTE, pend_byte_reg};
        take_new         = 1'b0;
        pend_valid_next  = pend_valid_reg;
        pend_odd_next    = pend_odd_reg;
        pend_byte_next   = pend_byte_reg;
        pend_region_next = pend_region_reg;
        pend_baddr_next  = pend_baddr_reg;
        pend_waddr_next  = pend_waddr_reg;

        if (state_reg == FLUSH) begin
          wr_en           = pend_valid_reg;
          pend_valid_next = 1'b0;
        end else if (state_reg == LOAD) begin
          if (byte_ok) begin
            if (pair_hit) begin
              wr_en           = 1'b1;
              wr_data         = {ioctl_dout, pend_byte_reg};
              pend_valid_next = 1'b0;
            end else if (pend_valid_reg) begin
              // Pending word can't be completed by this byte: write it out
              // padded and let the new byte take the slot.
              wr_en    = 1'b1;
              take_new = 1'b1;
            end else if (dec_offset[0]) begin
              // Lone odd byte: nothing to pair with, write it padded now.
              wr_en     = 1'b1;
              wr_region = dec_region;
              wr_addr   = word_off[ADDR_W-1:0];
              wr_data   = {ioctl_dout, FILL_BYTE};
            end else begin
              take_new = 1'b1;
            end
          end else if (pend_valid_reg && pend_odd_reg) begin
            wr_en           = 1'b1;
            pend_valid_next = 1'b0;
          end

          if (take_new) begin
            pend_valid_next  = 1'b1;
            pend_odd_next    = dec_offset[0];
            pend_byte_next   = ioctl_dout;
            pend_region_next = dec_region;
            pend_baddr_next  = ioctl_addr;
            pend_waddr_next  = word_off[ADDR_W-1:0];
          end
        end else begin
          pend_valid_next = 1'b0;
        end
      end

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          pend_valid_reg  <= 1'b0;
          pend_odd_reg    <= 1'b0;
          pend_byte_reg   <= '0;
          pend_region_reg <= REG_NONE;
          pend_baddr_reg  <= '0;
          pend_waddr_reg  <= '0;
        end else begin
          pend_valid_reg  <= pend_valid_next;
          pend_odd_reg    <= pend_odd_next;
          pend_byte_reg   <= pend_byte_next;
          pend_region_reg <= pend_region_next;
          pend_baddr_reg  <= pend_baddr_next;
          pend_waddr_reg  <= pend_waddr_next;
        end
      end
    end else begin : g_w8
      logic unused_w8;

      assign unused_w8 = ^dec_offset;

      always_comb begin
        wr_en     = byte_ok;
        wr_region = dec_region;
        wr_addr   = dec_offset[ADDR_W-1:0];
        wr_data   = ioctl_dout;
      end
    end
  endgenerate

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      dn_wr        <= '0;
      dn_addr      <= '0;
      dn_data      <= '0;
      oob_err      <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == FLUSH) begin
        hold_cnt_reg <= CNT_W'(HOLD_CYC - 1);
      end else if ((state_reg == HOLD) && (hold_cnt_reg != '0)) begin
        hold_cnt_reg <= hold_cnt_reg - CNT_W'(1);
      end

      dn_wr <= wr_en ? (NREG'(1) << wr_region) : '0;
      if (wr_en) begin
        dn_addr <= wr_addr;
        dn_data <= wr_data;
      end

      if (enter_load) begin
        oob_err <= 1'b0;
      end else if (byte_oob) begin
        oob_err <= 1'b1;
      end
    end
  end

  assign reset_out = (state_reg != READY);
  assign rom_ready = (state_reg == READY);

endmodule

// File: tb/tb_arcade_rom_loader.sv
// Directed bench for arcade_rom_loader. Two instances share one ioctl stream:
// an 8-bit build and a 16-bit build, both with two regions at 0x0000 and
// 0x8000 (32 KiB each) and a 16-cycle hold.
module tb_arcade_rom_loader;

  logic        clk;
  logic        rst;
  logic        dl;
  logic        wr;
  logic [24:0] addr;
  logic [7:0]  dout;
  logic [15:0] idx;

  logic [17:0] a8, a16;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [1:0]  w8, w16;
  logic        ro8, rr8, oob8;
  logic        ro16, rr16, oob16;

  int checks = 0;
  int errors = 0;

  localparam logic [49:0] BASES = {25'h8000, 25'h0};
  localparam logic [49:0] SIZES = {25'h8000, 25'h8000};

  arcade_rom_loader #(
    .NREG(2), .DATA_W(8), .ADDR_W(18), .ROM_INDEX(16'd0),
    .REG_BASE(BASES), .REG_SIZE(SIZES), .HOLD_CYC(16)
  ) dut8 (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx),
    .dn_addr(a8), .dn_data(d8), .dn_wr(w8),
    .reset_out(ro8), .rom_ready(rr8), .oob_err(oob8)
  );

  arcade_rom_loader #(
    .NREG(2), .DATA_W(16), .ADDR_W(18), .ROM_INDEX(16'd0),
    .REG_BASE(BASES), .REG_SIZE(SIZES), .HOLD_CYC(16)
  ) dut16 (
    .clk_sys(clk), .reset(rst), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx),
    .dn_addr(a16), .dn_data(d16), .dn_wr(w16),
    .reset_out(ro16), .rom_ready(rr16), .oob_err(oob16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  wr8;
    logic [17:0] a8;
    logic [7:0]  d8;
    logic [1:0]  wr16;
    logic [17:0] a16;
    logic [15:0] d16;
    logic        oob;
  } vec_t;

  vec_t vec [9];

  function automatic vec_t mk(input logic [24:0] ad, input logic [7:0] da,
                              input logic [1:0] ew8, input logic [17:0] ea8,
                              input logic [7:0] ed8, input logic [1:0] ew16,
                              input logic [17:0] ea16, input logic [15:0] ed16,
                              input logic eoob);
    vec_t v;
    v.addr = ad;  v.data = da;
    v.wr8  = ew8; v.a8 = ea8; v.d8 = ed8;
    v.wr16 = ew16; v.a16 = ea16; v.d16 = ed16;
    v.oob  = eoob;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int first_ready;
    logic prev_ro;
    int nwr16;
    logic seen;

    rst = 1'b1; dl = 1'b0; wr = 1'b0; addr = '0; dout = '0; idx = '0;

    //          addr       data   w8     a8      d8     w16    a16     d16       oob
    vec[0] = mk(25'h00000, 8'h11, 2'b01, 18'h0,  8'h11, 2'b00, 18'h0, 16'h0000, 1'b0);
    vec[1] = mk(25'h00001, 8'h22, 2'b01, 18'h1,  8'h22, 2'b01, 18'h0, 16'h2211, 1'b0);
    vec[2] = mk(25'h08000, 8'h33, 2'b10, 18'h0,  8'h33, 2'b00, 18'h0, 16'h2211, 1'b0);
    vec[3] = mk(25'h08004, 8'h44, 2'b10, 18'h4,  8'h44, 2'b10, 18'h0, 16'hFF33, 1'b0);
    vec[4] = mk(25'h08005, 8'h55, 2'b10, 18'h5,  8'h55, 2'b10, 18'h2, 16'h5544, 1'b0);
    vec[5] = mk(25'h00000, 8'hA5, 2'b01, 18'h0,  8'hA5, 2'b00, 18'h2, 16'h5544, 1'b0);
    vec[6] = mk(25'h00001, 8'h3C, 2'b01, 18'h1,  8'h3C, 2'b01, 18'h0, 16'h3CA5, 1'b0);
    vec[7] = mk(25'h20000, 8'h99, 2'b00, 18'h1,  8'h3C, 2'b00, 18'h0, 16'h3CA5, 1'b1);
    vec[8] = mk(25'h00010, 8'h77, 2'b01, 18'h10, 8'h77, 2'b00, 18'h0, 16'h3CA5, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst w8", 32'(w8), 32'h0);
    check("rst a8", 32'(a8), 32'h0);
    check("rst d8", 32'(d8), 32'h0);
    check("rst reset_out8", 32'(ro8), 32'h1);
    check("rst rom_ready8", 32'(rr8), 32'h0);
    check("rst oob8", 32'(oob8), 32'h0);
    check("rst w16", 32'(w16), 32'h0);
    check("rst d16", 32'(d16), 32'h0);
    check("rst reset_out16", 32'(ro16), 32'h1);

    @(negedge clk) rst = 1'b0;
    @(negedge clk) dl = 1'b1;
    @(posedge clk);
    #1;
    check("load reset_out", 32'(ro8), 32'h1);
    check("load rom_ready", 32'(rr8), 32'h0);

    // Table: one byte per vector, checked one cycle after the strobe
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      wr = 1'b1; addr = vec[i].addr; dout = vec[i].data;
      @(posedge clk);
      #1;
      $display("vec %0d addr=%h data=%h -> w8=%b a8=%h d8=%h | w16=%b a16=%h d16=%h oob=%b",
               i, vec[i].addr, vec[i].data, w8, a8, d8, w16, a16, d16, oob8);
      check($sformatf("v%0d w8", i),   32'(w8),   32'(vec[i].wr8));
      check($sformatf("v%0d a8", i),   32'(a8),   32'(vec[i].a8));
      check($sformatf("v%0d d8", i),   32'(d8),   32'(vec[i].d8));
      check($sformatf("v%0d w16", i),  32'(w16),  32'(vec[i].wr16));
      check($sformatf("v%0d a16", i),  32'(a16),  32'(vec[i].a16));
      check($sformatf("v%0d d16", i),  32'(d16),  32'(vec[i].d16));
      check($sformatf("v%0d oob8", i), 32'(oob8), 32'(vec[i].oob));
      @(negedge clk);
      wr = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d idle w8", i),  32'(w8),  32'h0);
      check($sformatf("v%0d idle w16", i), 32'(w16), 32'h0);
    end
    check("oob16 sticky", 32'(oob16), 32'h1);

    // End of download: flush of pending 0x77 and hold timing
    @(negedge clk) dl = 1'b0;
    first_ready = 0;
    prev_ro = 1'b0;
    for (int n = 1; n <= 40 && first_ready == 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) check("flush not early w16", 32'(w16), 32'h0);
      if (n == 2) begin
        $display("flush w16=%b a16=%h d16=%h", w16, a16, d16);
        check("flush w16", 32'(w16), 32'h1);
        check("flush a16", 32'(a16), 32'h8);
        check("flush d16", 32'(d16), 32'hFF77);
        check("flush w8", 32'(w8), 32'h0);
      end
      if (rr8) first_ready = n;
      else     prev_ro = ro8;
    end
    $display("end of load: rom_ready after %0d edges", first_ready);
    check("ready latency", 32'(first_ready), 32'd18);
    check("reset_out high before ready", 32'(prev_ro), 32'h1);
    check("reset_out low in ready", 32'(ro8), 32'h0);
    check("rom_ready16", 32'(rr16), 32'h1);

    // Foreign index download: ignored
    @(negedge clk);
    idx = 16'd1; dl = 1'b1;
    @(negedge clk);
    wr = 1'b1; addr = 25'h0; dout = 8'hEE;
    @(posedge clk);
    #1;
    $display("index1 byte: w8=%b w16=%b rom_ready=%b", w8, w16, rr8);
    check("idx1 w8", 32'(w8), 32'h0);
    check("idx1 w16", 32'(w16), 32'h0);
    check("idx1 rom_ready", 32'(rr8), 32'h1);
    check("idx1 reset_out", 32'(ro8), 32'h0);
    @(negedge clk);
    wr = 1'b0; dl = 1'b0;
    @(negedge clk) idx = 16'd0;

    // New download from READY: oob cleared; byte coincides with download fall
    @(negedge clk) dl = 1'b1;
    @(posedge clk);
    #1;
    check("reload oob8 cleared", 32'(oob8), 32'h0);
    check("reload oob16 cleared", 32'(oob16), 32'h0);
    check("reload rom_ready", 32'(rr8), 32'h0);
    check("reload reset_out", 32'(ro8), 32'h1);
    @(negedge clk);
    wr = 1'b1; addr = 25'h08002; dout = 8'h5A; dl = 1'b0;
    @(posedge clk);
    #1;
    $display("last byte at fall: w8=%b a8=%h d8=%h w16=%b", w8, a8, d8, w16);
    check("fall w8", 32'(w8), 32'h2);
    check("fall a8", 32'(a8), 32'h2);
    check("fall d8", 32'(d8), 32'h5A);
    check("fall w16", 32'(w16), 32'h0);
    @(negedge clk) wr = 1'b0;
    @(posedge clk);
    #1;
    $display("flush after fall: w16=%b a16=%h d16=%h", w16, a16, d16);
    check("fall flush w16", 32'(w16), 32'h2);
    check("fall flush a16", 32'(a16), 32'h1);
    check("fall flush d16", 32'(d16), 32'hFF5A);
    check("fall flush w8", 32'(w8), 32'h0);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (rr8) seen = 1'b1;
    end
    check("second load ready", 32'(seen), 32'h1);

    // Reset in the middle of a load with a half-word pending in dut16
    @(negedge clk) dl = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b1; addr = 25'h00100; dout = 8'hAB;
    @(posedge clk);
    #1;
    check("mid w8", 32'(w8), 32'h1);
    check("mid a8", 32'(a8), 32'h100);
    check("mid w16 buffered", 32'(w16), 32'h0);
    @(negedge clk);
    wr = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    $display("reset mid-load: reset_out=%b rom_ready=%b w16=%b d16=%h", ro16, rr16, w16, d16);
    check("midrst reset_out", 32'(ro16), 32'h1);
    check("midrst rom_ready", 32'(rr16), 32'h0);
    check("midrst a16", 32'(a16), 32'h0);
    check("midrst d16", 32'(d16), 32'h0);
    check("midrst d8", 32'(d8), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) dl = 1'b0;
    nwr16 = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (w16 != 2'b00) nwr16++;
    end
    $display("after mid-load reset: dut16 writes=%0d rom_ready=%b", nwr16, rr16);
    check("midrst no stale write", 32'(nwr16), 32'd0);
    check("midrst ready again", 32'(rr16), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
